// File: rtl/ysyx_210238_wb_unit_pkg.sv
// Shared definitions for the writeback unit: load size encodings, register
// address width and the {rd, data} writeback entry layout.
package ysyx_210238_wb_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WB_XLEN    = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  // Entry layout as stored in the LSU FIFO: rd in the upper bits, data below.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_210238_wb_fifo.sv
// Small synchronous FIFO (power-of-two depth >= 2) holding buffered load
// results; the caller never pushes when full nor pops when empty.
module ysyx_210238_wb_fifo #(
  parameter  int WIDTH = 69,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);

endmodule

// File: rtl/ysyx_210238_wb_unit.sv
// Writeback unit: arbitrates ALU and buffered LSU results onto one registered
// register-file write port and tracks pending writes. Optional perf counters
// are enabled with YSYX_210238_WB_PERF_CNT_EN.
module ysyx_210238_wb_unit
  import ysyx_210238_wb_unit_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Handshakes: a source transfers in a cycle where valid & ready are both
  // high; ready never depends on the same source's valid.
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_data,
  input  logic                  i_lsu_valid,
  output logic                  o_lsu_ready,
  input  logic [REG_ADDR_W-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]       i_lsu_data,
  input  logic [1:0]            i_lsu_size,
  input  logic                  i_lsu_unsigned,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  output logic                  o_wen,
  output logic [REG_ADDR_W-1:0] o_addr,
  output logic [XLEN-1:0]       o_wdata
`ifdef YSYX_210238_WB_PERF_CNT_EN
  ,
  output logic [63:0]           o_wb_cnt,
  output logic [63:0]           o_alu_stall_cnt
`endif
);

  localparam int ENT_W = REG_ADDR_W + XLEN;
  localparam int CNT_W = $clog2(LSU_FIFO_DEPTH) + 1;
  localparam int NREGS = 1 << REG_ADDR_W;

  logic [ENT_W-1:0]      push_ent;
  logic [ENT_W-1:0]      head_ent;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  lsu_push;
  logic                  fifo_pop;
  logic [XLEN-1:0]       lsu_ext;
  logic                  sel_valid;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic                  sel_write;
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_d;

  // Loads are older than anything the ALU is offering, so the ALU waits
  // until the FIFO has fully drained.
  assign o_lsu_ready = ~fifo_full;
  assign o_alu_ready = fifo_empty;
  assign lsu_push    = i_lsu_valid & ~fifo_full;
  assign fifo_pop    = ~fifo_empty;

  always_comb begin
    lsu_ext = i_lsu_data;
    case (lsu_size_e'(i_lsu_size))
      SZ_B:    lsu_ext = {{(XLEN-8){~i_lsu_unsigned & i_lsu_data[7]}}, i_lsu_data[7:0]};
      SZ_H:    lsu_ext = {{(XLEN-16){~i_lsu_unsigned & i_lsu_data[15]}}, i_lsu_data[15:0]};
      SZ_W:    lsu_ext = {{(XLEN-32){~i_lsu_unsigned & i_lsu_data[31]}}, i_lsu_data[31:0]};
      default: lsu_ext = i_lsu_data;
    endcase
  end

  assign push_ent = {i_lsu_rd, lsu_ext};

  ysyx_210238_wb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lsu_push),
    .push_data (push_ent),
    .pop       (fifo_pop),
    .pop_data  (head_ent),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_rd    = head_ent[ENT_W-1:XLEN];
      sel_data  = head_ent[XLEN-1:0];
    end else if (i_alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = i_alu_rd;
      sel_data  = i_alu_data;
    end
  end

  // rd=0 results are consumed but never reach the register file.
  assign sel_write = sel_valid & (sel_rd != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_wen   <= 1'b0;
      o_addr  <= '0;
      o_wdata <= '0;
    end else begin
      o_wen <= sel_write;
      if (sel_write) begin
        o_addr  <= sel_rd;
        o_wdata <= sel_data;
      end
    end
  end

  // A new issue to the register being written back wins over the clear.
  always_comb begin
    busy_d = busy_q;
    if (o_wen) busy_d[o_addr] = 1'b0;
    if (i_issue_valid && (i_issue_rd != '0)) busy_d[i_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign o_rs1_busy = busy_q[i_rs1_addr] & ~(o_wen & (o_addr == i_rs1_addr));
  assign o_rs2_busy = busy_q[i_rs2_addr] & ~(o_wen & (o_addr == i_rs2_addr));

  always_ff @(posedge clk) begin
    if (rst_n) assert (fifo_count <= CNT_W'(LSU_FIFO_DEPTH));
  end

`ifdef YSYX_210238_WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_wb_cnt        <= '0;
      o_alu_stall_cnt <= '0;
    end else begin
      if (o_wen) o_wb_cnt <= o_wb_cnt + 64'd1;
      if (i_alu_valid & ~o_alu_ready) o_alu_stall_cnt <= o_alu_stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_210238_wb_unit.sv
// Self-checking bench for ysyx_210238_wb_unit: directed scenarios plus random
// traffic compared against a queue-based behavioural model.
module tb_ysyx_210238_wb_unit;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_alu_valid;
  logic            o_alu_ready;
  logic [4:0]      i_alu_rd;
  logic [XLEN-1:0] i_alu_data;
  logic            i_lsu_valid;
  logic            o_lsu_ready;
  logic [4:0]      i_lsu_rd;
  logic [XLEN-1:0] i_lsu_data;
  logic [1:0]      i_lsu_size;
  logic            i_lsu_unsigned;
  logic            i_issue_valid;
  logic [4:0]      i_issue_rd;
  logic [4:0]      i_rs1_addr;
  logic [4:0]      i_rs2_addr;
  logic            o_rs1_busy;
  logic            o_rs2_busy;
  logic            o_wen;
  logic [4:0]      o_addr;
  logic [XLEN-1:0] o_wdata;
`ifdef YSYX_210238_WB_PERF_CNT_EN
  logic [63:0]     o_wb_cnt;
  logic [63:0]     o_alu_stall_cnt;
`endif

  ysyx_210238_wb_unit #(.XLEN(XLEN), .LSU_FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_alu_valid    (i_alu_valid),
    .o_alu_ready    (o_alu_ready),
    .i_alu_rd       (i_alu_rd),
    .i_alu_data     (i_alu_data),
    .i_lsu_valid    (i_lsu_valid),
    .o_lsu_ready    (o_lsu_ready),
    .i_lsu_rd       (i_lsu_rd),
    .i_lsu_data     (i_lsu_data),
    .i_lsu_size     (i_lsu_size),
    .i_lsu_unsigned (i_lsu_unsigned),
    .i_issue_valid  (i_issue_valid),
    .i_issue_rd     (i_issue_rd),
    .i_rs1_addr     (i_rs1_addr),
    .i_rs2_addr     (i_rs2_addr),
    .o_rs1_busy     (o_rs1_busy),
    .o_rs2_busy     (o_rs2_busy),
    .o_wen          (o_wen),
    .o_addr         (o_addr),
    .o_wdata        (o_wdata)
`ifdef YSYX_210238_WB_PERF_CNT_EN
    ,
    .o_wb_cnt        (o_wb_cnt),
    .o_alu_stall_cnt (o_alu_stall_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t        lsu_q[$];
  bit [31:0]   busy_m;
  bit          m_wen;
  logic [4:0]  m_addr;
  logic [63:0] m_data;
  bit          model_valid = 0;

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz, input logic uns);
    int          bits;
    logic [63:0] mask;
    logic [63:0] v;
    if (sz == 2'd3) return d;
    bits = 8 << sz;
    mask = (64'd1 << bits) - 64'd1;
    v    = d & mask;
    if (!uns && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit m_rs_busy(input logic [4:0] rs);
    return busy_m[rs] && !(m_wen && m_addr == rs);
  endfunction

  task automatic compare_outputs();
    check("lsu_ready", o_lsu_ready, lsu_q.size() < DEPTH);
    check("alu_ready", o_alu_ready, lsu_q.size() == 0);
    check("rs1_busy", o_rs1_busy, m_rs_busy(i_rs1_addr));
    check("rs2_busy", o_rs2_busy, m_rs_busy(i_rs2_addr));
    check("wen", o_wen, m_wen);
    if (m_wen) begin
      check("addr", o_addr, m_addr);
      check("wdata", o_wdata, m_data);
    end
    check("fifo_cnt_range", dut.u_fifo.count <= DEPTH, 1'b1);
  endtask

  task automatic model_next();
    int   sz;
    bit   wr;
    ent_t e;
    if (!rst_n) begin
      lsu_q.delete();
      busy_m      = '0;
      m_wen       = 0;
      m_addr      = '0;
      m_data      = '0;
      model_valid = 1;
      return;
    end
    sz = lsu_q.size();
    wr = 1;
    if (sz > 0) e = lsu_q.pop_front();
    else if (i_alu_valid) e = '{i_alu_rd, i_alu_data};
    else wr = 0;
    if (i_lsu_valid && sz < DEPTH)
      lsu_q.push_back('{i_lsu_rd, extend(i_lsu_data, i_lsu_size, i_lsu_unsigned)});
    if (m_wen) busy_m[m_addr] = 0;
    if (i_issue_valid && i_issue_rd != 0) busy_m[i_issue_rd] = 1;
    m_wen = wr && e.rd != 0;
    if (m_wen) begin
      m_addr = e.rd;
      m_data = e.data;
    end
  endtask

  // ---------------- driver ----------------
  task automatic clear_inputs();
    i_alu_valid    = 0;
    i_alu_rd       = '0;
    i_alu_data     = '0;
    i_lsu_valid    = 0;
    i_lsu_rd       = '0;
    i_lsu_data     = '0;
    i_lsu_size     = '0;
    i_lsu_unsigned = 0;
    i_issue_valid  = 0;
    i_issue_rd     = '0;
    i_rs1_addr     = '0;
    i_rs2_addr     = '0;
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic step_cycle();
    #1;
    if (model_valid) compare_outputs();
    model_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [1:0]  t_size [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
  logic        t_uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [63:0] t_data [4] = '{64'h80, 64'h80, 64'h8001, 64'h7FFF_FFFF};
  logic [63:0] t_exp  [4] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80,
                              64'hFFFF_FFFF_FFFF_8001, 64'h7FFF_FFFF};

  initial begin
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    step_cycle();
    step_cycle();
    rst_n = 1;
    #1;
    check("rst_wen", o_wen, 1'b0);
    check("rst_addr", o_addr, 5'd0);
    check("rst_wdata", o_wdata, 64'd0);
    check("rst_alu_ready", o_alu_ready, 1'b1);
    check("rst_lsu_ready", o_lsu_ready, 1'b1);

    // ALU only
    i_alu_valid = 1; i_alu_rd = 5'd5; i_alu_data = 64'h1234;
    #1 check("alu_only_ready", o_alu_ready, 1'b1);
    step_cycle();
    clear_inputs();
    #1;
    check("alu_only_wen", o_wen, 1'b1);
    check("alu_only_addr", o_addr, 5'd5);
    check("alu_only_wdata", o_wdata, 64'h1234);
    step_cycle();
    check("alu_only_idle", o_wen, 1'b0);

    // Load extension
    for (int k = 0; k < 4; k++) begin
      i_lsu_valid = 1; i_lsu_rd = 5'd9; i_lsu_data = t_data[k];
      i_lsu_size = t_size[k]; i_lsu_unsigned = t_uns[k];
      step_cycle();
      clear_inputs();
      step_cycle();
      check("ext_wen", o_wen, 1'b1);
      check("ext_wdata", o_wdata, t_exp[k]);
      step_cycle();
    end

    // Contention: ALU rd=3 and LSU rd=4 together on an empty FIFO
    i_alu_valid = 1; i_alu_rd = 5'd3; i_alu_data = 64'hA3;
    i_lsu_valid = 1; i_lsu_rd = 5'd4; i_lsu_data = 64'hB4; i_lsu_size = 2'd3;
    step_cycle();
    clear_inputs();
    #1;
    check("cont_alu_addr", o_addr, 5'd3);
    check("cont_alu_wdata", o_wdata, 64'hA3);
    step_cycle();
    check("cont_lsu_wen", o_wen, 1'b1);
    check("cont_lsu_addr", o_addr, 5'd4);
    check("cont_lsu_wdata", o_wdata, 64'hB4);

    // Back-to-back loads keep the ALU stalled until the FIFO drains
    for (int k = 0; k < 3; k++) begin
      i_alu_valid = 1; i_alu_rd = 5'd20; i_alu_data = 64'hCC;
      i_lsu_valid = 1; i_lsu_rd = 5'(10 + k); i_lsu_data = 64'(k); i_lsu_size = 2'd3;
      step_cycle();
    end
    i_lsu_valid = 0;
    #1 check("stall_alu_ready", o_alu_ready, 1'b0);
    step_cycle();
    #1 check("drain_alu_ready", o_alu_ready, 1'b1);
    step_cycle();
    clear_inputs();
    #1;
    check("drain_alu_addr", o_addr, 5'd20);
    step_cycle();

    // Scoreboard
    i_issue_valid = 1; i_issue_rd = 5'd7;
    step_cycle();
    clear_inputs();
    i_rs1_addr = 5'd7;
    #1 check("sb_set", o_rs1_busy, 1'b1);
    i_alu_valid = 1; i_alu_rd = 5'd7; i_alu_data = 64'h77;
    step_cycle();
    clear_inputs();
    i_rs1_addr = 5'd7; i_issue_valid = 1; i_issue_rd = 5'd7;
    #1;
    check("sb_wb_addr", o_addr, 5'd7);
    check("sb_clear_visible", o_rs1_busy, 1'b0);
    step_cycle();
    clear_inputs();
    i_rs1_addr = 5'd7;
    #1 check("sb_set_wins", o_rs1_busy, 1'b1);
    step_cycle();

    // rd=0
    i_alu_valid = 1; i_alu_rd = 5'd0; i_alu_data = 64'hDEAD;
    i_issue_valid = 1; i_issue_rd = 5'd0;
    #1 check("rd0_ready", o_alu_ready, 1'b1);
    step_cycle();
    clear_inputs();
    #1;
    check("rd0_wen", o_wen, 1'b0);
    check("rd0_busy", o_rs1_busy, 1'b0);
    step_cycle();

    // Reset with a buffered load and busy bits set
    i_issue_valid = 1; i_issue_rd = 5'd12;
    step_cycle();
    i_issue_rd = 5'd13; i_lsu_valid = 1; i_lsu_rd = 5'd14; i_lsu_size = 2'd3;
    step_cycle();
    rst_n = 0;
    step_cycle();
    rst_n = 1;
    clear_inputs();
    i_rs1_addr = 5'd12; i_rs2_addr = 5'd13;
    #1;
    check("mid_rst_wen", o_wen, 1'b0);
    check("mid_rst_alu_ready", o_alu_ready, 1'b1);
    check("mid_rst_lsu_ready", o_lsu_ready, 1'b1);
    check("mid_rst_rs1", o_rs1_busy, 1'b0);
    check("mid_rst_rs2", o_rs2_busy, 1'b0);
    check("mid_rst_cnt", dut.u_fifo.count, 64'd0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n          = ($urandom_range(0, 299) != 0);
      i_alu_valid    = $urandom_range(0, 1);
      i_alu_rd       = 5'($urandom_range(0, 7));
      i_alu_data     = {$urandom, $urandom};
      i_lsu_valid    = ($urandom_range(0, 2) == 0);
      i_lsu_rd       = 5'($urandom_range(0, 7));
      i_lsu_data     = {$urandom, $urandom};
      i_lsu_size     = 2'($urandom_range(0, 3));
      i_lsu_unsigned = $urandom_range(0, 1);
      i_issue_valid  = $urandom_range(0, 1);
      i_issue_rd     = 5'($urandom_range(0, 7));
      i_rs1_addr     = 5'($urandom_range(0, 7));
      i_rs2_addr     = 5'($urandom_range(0, 7));
      step_cycle();
    end
    rst_n = 1;
    clear_inputs();
    step_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
